mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single external bus/memory port between instruction fetch (IF) and the MEM-stage load/store of the 5-stage RISC-V pipeline.
- Sequences variable-latency bus transactions with a req/ack handshake.
- Raises per-side stall requests that the hazard/stall logic ORs into its stall_PC/stall_IF_ID and stall_EX_MEM/stall_MEM_WB outputs.
- Discards in-flight fetches killed by a control-hazard flush.

Parameters:
- AW, 32, address width.
- DW, 32, data width; wmask width is DW/8.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- if_req  in  1  fetch request; held until if_ready or flush_if.
- if_addr  in  AW  fetch address (PC); stable while if_req.
- flush_if  in  1  control-hazard flush (npc_op); kills the current or pending fetch.
- if_rdata  out  DW  fetched instruction; valid when if_ready.
- if_ready  out  1  one-cycle fetch-complete pulse.
- mem_req  in  1  data request; held until mem_ready.
- mem_we  in  1  1=store, 0=load.
- mem_addr  in  AW  data address.
- mem_wdata  in  DW  store data.
- mem_wmask  in  DW/8  byte enables.
- mem_rdata  out  DW  load data; valid when mem_ready.
- mem_ready  out  1  one-cycle data-complete pulse (loads and stores).
- bus_req  out  1  bus request; held until bus_ack.
- bus_we, bus_addr, bus_wdata, bus_wmask  out  1/AW/DW/DW/8  registered copy of the granted request.
- bus_ack  in  1  one-cycle completion; bus_rdata valid the same cycle.
- bus_rdata  in  DW  bus read data.
- stall_if  out  1  combinational: (if_req & ~if_ready & ~flush_if) | stall_mem.
- stall_mem  out  1  combinational: mem_req & ~mem_ready.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. bus_req, bus_we, if_ready, mem_ready = 0. bus_addr, bus_wdata, bus_wmask, if_rdata, mem_rdata = 0. last_grant=IF.
- FSM states: IDLE, IF_BUSY, D_BUSY, IF_DROP.
- IDLE grant, evaluated on the clock edge:
  - mem_req & (~if_req | last_grant==IF | flush_if) -> D_BUSY.
  - else if_req & ~flush_if -> IF_BUSY.
  - else stay IDLE.
- On grant, capture the request into bus_* and set bus_req=1 at the next edge. Request-to-bus latency is 1 cycle.
- Entering IF_BUSY or D_BUSY updates last_grant. This gives data priority except directly after a data grant while IF is waiting, so fetch cannot starve.
- A suppressed or ungranted request stays pending. The requester holds it.
- IF_BUSY:
  - bus_ack -> latch bus_rdata into if_rdata, pulse if_ready for 1 cycle, clear bus_req, go IDLE.
  - flush_if without bus_ack -> IF_DROP, bus_req stays high. The bus cannot be aborted.
  - flush_if and bus_ack in the same cycle -> no if_ready, go IDLE.
- IF_DROP: on bus_ack, clear bus_req, go IDLE, no if_ready. if_rdata keeps its old value.
- D_BUSY: on bus_ack, latch bus_rdata into mem_rdata (loads only; stores leave it unchanged), pulse mem_ready for 1 cycle, clear bus_req, go IDLE. flush_if has no effect on data.
- Back-to-back grants: a new grant is taken no earlier than the IDLE cycle after completion. Minimum transaction period is 3 cycles with a zero-wait bus (grant, ack, idle).
- bus_ack while in IDLE (stale ack after reset) is ignored.
- bus_* fields are stable throughout bus_req=1.
- if_ready/mem_ready are registered 1-cycle pulses. Requesters must deassert or advance their request the cycle after the pulse.
- Reset mid-transaction: the FSM returns to IDLE immediately and the outstanding bus cycle is abandoned.
- No arithmetic. Addresses pass through untouched; no alignment checks in this block.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined, add outputs perf_if_stall (32) and perf_mem_stall (32).
  - They count cycles with stall_if=1 and stall_mem=1 respectively.
  - Both reset to 0 and saturate at 0xFFFFFFFF, no wrap.
- When undefined, the ports and counters do not exist. Arbitration behaviour is identical either way.

Test Plan:
- Single fetch: if_req=1, if_addr=0x1000, bus_ack 2 cycles after bus_req with rdata=0x00500093 -> bus_addr=0x1000, if_ready pulse 1 cycle after ack, if_rdata=0x00500093, stall_if=1 until the pulse.
- Simultaneous requests, last_grant=IF: if_req and mem_req (load 0x2000) -> data granted first; mem_ready with mem_rdata=bus_rdata; then the fetch is granted. stall_if stays 1 throughout.
- Fairness: mem_req issued again immediately after a data completion while if_req is pending -> IF granted next, then data.
- Flush mid-fetch: flush_if in IF_BUSY before ack -> IF_DROP; ack with 0xDEADBEEF gives no if_ready and if_rdata unchanged; a new fetch at 0x3000 is granted afterwards. Repeat with flush and ack in the same cycle -> no if_ready.
- Store: mem_we=1, addr=0x2004, wdata=0xA5A5A5A5, wmask=0xF -> bus_we=1 and bus fields match; mem_ready pulses; mem_rdata unchanged.
- Async reset asserted in D_BUSY -> bus_req=0 and state IDLE without waiting for a clock edge; a later stray bus_ack gives no ready pulse. With ARB_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external bus port between instruction fetch
// and the MEM-stage load/store. One bus transaction is outstanding at a time;
// data normally wins, except directly after a data grant while a fetch waits.
// A fetch killed by flush_if still completes on the bus but is discarded.
// Optional macro ARB_PERF_CNT_EN adds saturating stall-cycle counters.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_if_req,
    input  logic [AW-1:0]   i_if_addr,
    input  logic            i_flush_if,
    output logic [DW-1:0]   o_if_rdata,
    output logic            o_if_ready,
    input  logic            i_mem_req,
    input  logic            i_mem_we,
    input  logic [AW-1:0]   i_mem_addr,
    input  logic [DW-1:0]   i_mem_wdata,
    input  logic [DW/8-1:0] i_mem_wmask,
    output logic [DW-1:0]   o_mem_rdata,
    output logic            o_mem_ready,
    output logic            o_bus_req,
    output logic            o_bus_we,
    output logic [AW-1:0]   o_bus_addr,
    output logic [DW-1:0]   o_bus_wdata,
    output logic [DW/8-1:0] o_bus_wmask,
    input  logic            i_bus_ack,
    input  logic [DW-1:0]   i_bus_rdata,
    output logic            o_stall_if,
    output logic            o_stall_mem
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]     o_perf_if_stall,
    output logic [31:0]     o_perf_mem_stall
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_D_BUSY  = 2'd2,
        ST_IF_DROP = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last_data;   // 1 = most recent grant went to data
    logic            w_last_data;
    logic            r_bus_req, w_bus_req;
    logic            r_bus_we, w_bus_we;
    logic [AW-1:0]   r_bus_addr, w_bus_addr;
    logic [DW-1:0]   r_bus_wdata, w_bus_wdata;
    logic [DW/8-1:0] r_bus_wmask, w_bus_wmask;
    logic [DW-1:0]   r_if_rdata, w_if_rdata;
    logic [DW-1:0]   r_mem_rdata, w_mem_rdata;
    logic            r_if_ready, w_if_ready;
    logic            r_mem_ready, w_mem_ready;
    logic            w_if_cand;
    logic            w_mem_cand;
    logic            w_stall_if;
    logic            w_stall_mem;

    // A requester still holds its request during its own ready pulse; that
    // request is already served, so it must not be granted a second time.
    assign w_if_cand   = i_if_req & ~r_if_ready;
    assign w_mem_cand  = i_mem_req & ~r_mem_ready;
    assign w_stall_mem = w_mem_cand;
    assign w_stall_if  = (w_if_cand & ~i_flush_if) | w_stall_mem;

    assign o_stall_if  = w_stall_if;
    assign o_stall_mem = w_stall_mem;
    assign o_bus_req   = r_bus_req;
    assign o_bus_we    = r_bus_we;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wdata = r_bus_wdata;
    assign o_bus_wmask = r_bus_wmask;
    assign o_if_rdata  = r_if_rdata;
    assign o_if_ready  = r_if_ready;
    assign o_mem_rdata = r_mem_rdata;
    assign o_mem_ready = r_mem_ready;

    // FSM state register; reset abandons any outstanding bus cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, grant decision and next values of all registered outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_last_data = r_last_data;
        w_bus_req   = r_bus_req;
        w_bus_we    = r_bus_we;
        w_bus_addr  = r_bus_addr;
        w_bus_wdata = r_bus_wdata;
        w_bus_wmask = r_bus_wmask;
        w_if_rdata  = r_if_rdata;
        w_mem_rdata = r_mem_rdata;
        w_if_ready  = 1'b0;
        w_mem_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Stray acks here are ignored: nothing is outstanding.
                if (w_mem_cand && (!w_if_cand || !r_last_data || i_flush_if)) begin
                    w_state_nxt = ST_D_BUSY;
                    w_last_data = 1'b1;
                    w_bus_req   = 1'b1;
                    w_bus_we    = i_mem_we;
                    w_bus_addr  = i_mem_addr;
                    w_bus_wdata = i_mem_wdata;
                    w_bus_wmask = i_mem_wmask;
                end else if (w_if_cand && !i_flush_if) begin
                    w_state_nxt = ST_IF_BUSY;
                    w_last_data = 1'b0;
                    w_bus_req   = 1'b1;
                    w_bus_we    = 1'b0;
                    w_bus_addr  = i_if_addr;
                    w_bus_wdata = '0;
                    w_bus_wmask = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IF_BUSY: begin
                if (i_bus_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_bus_req   = 1'b0;
                    if (!i_flush_if) begin
                        w_if_ready = 1'b1;
                        w_if_rdata = i_bus_rdata;
                    end else begin
                        w_if_ready = 1'b0;
                    end
                end else if (i_flush_if) begin
                    // The bus cycle cannot be aborted; wait it out and discard.
                    w_state_nxt = ST_IF_DROP;
                end else begin
                    w_state_nxt = ST_IF_BUSY;
                end
            end
            ST_D_BUSY: begin
                if (i_bus_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_bus_req   = 1'b0;
                    w_mem_ready = 1'b1;
                    if (!r_bus_we) begin
                        w_mem_rdata = i_bus_rdata;
                    end else begin
                        w_mem_rdata = r_mem_rdata;
                    end
                end else begin
                    w_state_nxt = ST_D_BUSY;
                end
            end
            ST_IF_DROP: begin
                if (i_bus_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_bus_req   = 1'b0;
                end else begin
                    w_state_nxt = ST_IF_DROP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_bus_req   = 1'b0;
            end
        endcase
    end

    // Registered bus copy, read data, ready pulses and grant history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_data <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wmask <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
        end else begin
            r_last_data <= w_last_data;
            r_bus_req   <= w_bus_req;
            r_bus_we    <= w_bus_we;
            r_bus_addr  <= w_bus_addr;
            r_bus_wdata <= w_bus_wdata;
            r_bus_wmask <= w_bus_wmask;
            r_if_rdata  <= w_if_rdata;
            r_mem_rdata <= w_mem_rdata;
            r_if_ready  <= w_if_ready;
            r_mem_ready <= w_mem_ready;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_if;
    logic [31:0] r_perf_mem;

    assign o_perf_if_stall  = r_perf_if;
    assign o_perf_mem_stall = r_perf_mem;

    // Saturating counters of cycles spent stalled on each side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_if  <= 32'd0;
            r_perf_mem <= 32'd0;
        end else begin
            if (w_stall_if && (r_perf_if != 32'hFFFF_FFFF)) begin
                r_perf_if <= r_perf_if + 32'd1;
            end else begin
                r_perf_if <= r_perf_if;
            end
            if (w_stall_mem && (r_perf_mem != 32'hFFFF_FFFF)) begin
                r_perf_mem <= r_perf_mem + 32'd1;
            end else begin
                r_perf_mem <= r_perf_mem;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by a randomized
// phase checked against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, flush_if, if_ready;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          mem_req, mem_we, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [3:0]    mem_wmask;
    logic          bus_req, bus_we, bus_ack;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata, bus_rdata;
    logic [3:0]    bus_wmask;
    logic          stall_if, stall_mem;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]   perf_if, perf_mem;
`endif

    int total = 0;
    int bad   = 0;

    // Model state: one outstanding bus transaction and who owns it.
    bit          m_busy, m_is_fetch, m_kill, m_last_data, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wmask;
    logic        e_if_ready, e_mem_ready, s_if, s_mem, if_cand, mem_cand;
    logic [31:0] e_if_rdata, e_mem_rdata;
    bit          prev_if_done, prev_mem_done, prev_flush;
    logic [31:0] m_perf_if, m_perf_mem;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_flush_if(flush_if),
        .o_if_rdata(if_rdata), .o_if_ready(if_ready),
        .i_mem_req(mem_req), .i_mem_we(mem_we), .i_mem_addr(mem_addr),
        .i_mem_wdata(mem_wdata), .i_mem_wmask(mem_wmask),
        .o_mem_rdata(mem_rdata), .o_mem_ready(mem_ready),
        .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
        .o_bus_wdata(bus_wdata), .o_bus_wmask(bus_wmask),
        .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata),
        .o_stall_if(stall_if), .o_stall_mem(stall_mem)
`ifdef ARB_PERF_CNT_EN
        , .o_perf_if_stall(perf_if), .o_perf_mem_stall(perf_mem)
`endif
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0; flush_if = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
        mem_wmask = 4'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        cyc(); cyc(); smp();
        // reset state
        chk1("rst_bus_req", bus_req, 1'b0);
        chk1("rst_bus_we", bus_we, 1'b0);
        chk1("rst_if_ready", if_ready, 1'b0);
        chk1("rst_mem_ready", mem_ready, 1'b0);
        chk32("rst_bus_addr", bus_addr, 32'h0);
        chk32("rst_bus_wdata", bus_wdata, 32'h0);
        chk32("rst_bus_wmask", 32'(bus_wmask), 32'h0);
        chk32("rst_if_rdata", if_rdata, 32'h0);
        chk32("rst_mem_rdata", mem_rdata, 32'h0);
`ifdef ARB_PERF_CNT_EN
        chk32("rst_perf_if", perf_if, 32'h0);
        chk32("rst_perf_mem", perf_mem, 32'h0);
`endif
        // single fetch
        cyc(); rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h1000;
        smp(); chk1("f1_stall", stall_if, 1'b1); chk1("f1_noreq", bus_req, 1'b0);
        cyc(); smp(); chk1("f1_req", bus_req, 1'b1); chk32("f1_addr", bus_addr, 32'h1000);
        chk1("f1_we", bus_we, 1'b0);
        cyc(); smp(); chk1("f1_hold", bus_req, 1'b1); chk32("f1_addr_stable", bus_addr, 32'h1000);
        cyc(); bus_ack = 1'b1; bus_rdata = 32'h0050_0093;
        smp(); chk1("f1_noready", if_ready, 1'b0); chk1("f1_stall_ack", stall_if, 1'b1);
        cyc(); bus_ack = 1'b0;
        smp(); chk1("f1_ready", if_ready, 1'b1); chk32("f1_rdata", if_rdata, 32'h0050_0093);
        chk1("f1_stall_rdy", stall_if, 1'b0); chk1("f1_req_clr", bus_req, 1'b0);
        cyc(); if_req = 1'b0;
        smp(); chk1("f1_pulse_end", if_ready, 1'b0); chk1("f1_no_regrant", bus_req, 1'b0);
        // simultaneous requests after an IF grant: data first, then fetch
        cyc(); if_req = 1'b1; if_addr = 32'h1004; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000;
        smp(); chk1("s_stall_if", stall_if, 1'b1); chk1("s_stall_mem", stall_mem, 1'b1);
        cyc(); smp(); chk1("s_req", bus_req, 1'b1); chk32("s_addr_d", bus_addr, 32'h2000);
        cyc(); bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
        cyc(); bus_ack = 1'b0;
        smp(); chk1("s_mready", mem_ready, 1'b1); chk32("s_mrdata", mem_rdata, 32'h1122_3344);
        chk1("s_stall_mem0", stall_mem, 1'b0); chk1("s_stall_if1", stall_if, 1'b1);
        // fairness: data re-requests at once but the waiting fetch goes first
        cyc(); mem_addr = 32'h2008;
        smp(); chk1("fair_req", bus_req, 1'b1); chk32("fair_addr_if", bus_addr, 32'h1004);
        chk1("fair_mready0", mem_ready, 1'b0);
        cyc(); bus_ack = 1'b1; bus_rdata = 32'h00A0_0113;
        cyc(); bus_ack = 1'b0;
        smp(); chk1("fair_iready", if_ready, 1'b1); chk32("fair_irdata", if_rdata, 32'h00A0_0113);
        chk1("fair_stall_if", stall_if, 1'b1);
        cyc(); if_req = 1'b0;
        smp(); chk1("fair_req_d", bus_req, 1'b1); chk32("fair_addr_d", bus_addr, 32'h2008);
        cyc(); bus_ack = 1'b1; bus_rdata = 32'h5566_7788;
        cyc(); bus_ack = 1'b0;
        smp(); chk1("fair_mready", mem_ready, 1'b1); chk32("fair_mrdata", mem_rdata, 32'h5566_7788);
        cyc(); mem_req = 1'b0;
        smp(); chk1("fair_idle", bus_req, 1'b0); chk1("fair_stall_mem", stall_mem, 1'b0);
        // flush mid-fetch, then a new fetch, then flush with ack together
        cyc(); if_req = 1'b1; if_addr = 32'h1008;
        cyc(); smp(); chk32("fl_addr", bus_addr, 32'h1008);
        cyc(); flush_if = 1'b1;
        smp(); chk1("fl_stall0", stall_if, 1'b0);
        cyc(); flush_if = 1'b0; if_addr = 32'h3000;
        smp(); chk1("fl_drop_req", bus_req, 1'b1); chk32("fl_addr_stable", bus_addr, 32'h1008);
        cyc(); bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        cyc(); bus_ack = 1'b0;
        smp(); chk1("fl_noready", if_ready, 1'b0); chk32("fl_rdata_keep", if_rdata, 32'h00A0_0113);
        chk1("fl_req_clr", bus_req, 1'b0);
        cyc(); smp(); chk1("fl_new_req", bus_req, 1'b1); chk32("fl_new_addr", bus_addr, 32'h3000);
        cyc(); flush_if = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        cyc(); flush_if = 1'b0; bus_ack = 1'b0; if_req = 1'b0;
        smp(); chk1("fa_noready", if_ready, 1'b0); chk1("fa_req_clr", bus_req, 1'b0);
        chk32("fa_rdata_keep", if_rdata, 32'h00A0_0113);
        // store
        cyc(); mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2004; mem_wdata = 32'hA5A5_A5A5; mem_wmask = 4'hF;
        cyc(); smp(); chk1("st_we", bus_we, 1'b1); chk32("st_addr", bus_addr, 32'h2004);
        chk32("st_wdata", bus_wdata, 32'hA5A5_A5A5); chk32("st_wmask", 32'(bus_wmask), 32'hF);
        cyc(); bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        cyc(); bus_ack = 1'b0;
        smp(); chk1("st_ready", mem_ready, 1'b1); chk32("st_rdata_keep", mem_rdata, 32'h5566_7788);
        cyc(); mem_req = 1'b0; mem_we = 1'b0;
        // asynchronous reset in the middle of a data transaction
        cyc(); mem_req = 1'b1; mem_addr = 32'h2010;
        cyc(); smp(); chk1("ar_req", bus_req, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk1("ar_req_clr", bus_req, 1'b0); chk32("ar_addr_clr", bus_addr, 32'h0);
        chk32("ar_mrdata_clr", mem_rdata, 32'h0);
`ifdef ARB_PERF_CNT_EN
        chk32("ar_perf_if", perf_if, 32'h0);
        chk32("ar_perf_mem", perf_mem, 32'h0);
`endif
        cyc(); mem_req = 1'b0;
        cyc(); rst_n = 1'b1; bus_ack = 1'b1;
        cyc(); bus_ack = 1'b0;
        smp(); chk1("ar_stray_m", mem_ready, 1'b0); chk1("ar_stray_i", if_ready, 1'b0);
        chk1("ar_stray_req", bus_req, 1'b0);

        // randomized phase from a fresh reset
        cyc(); rst_n = 1'b0;
        cyc(); rst_n = 1'b1;
        m_busy = 1'b0; m_is_fetch = 1'b0; m_kill = 1'b0; m_last_data = 1'b0; m_we = 1'b0;
        m_addr = 32'h0; m_wdata = 32'h0; m_wmask = 4'h0;
        e_if_ready = 1'b0; e_mem_ready = 1'b0; e_if_rdata = 32'h0; e_mem_rdata = 32'h0;
        prev_if_done = 1'b0; prev_mem_done = 1'b0; prev_flush = 1'b0;
        m_perf_if = 32'h0; m_perf_mem = 32'h0;
        for (int c = 0; c < 1500; c++) begin
            cyc();
            // fetch requester: hold until served or flushed, then maybe a new PC
            if (if_req && (prev_if_done || prev_flush)) begin
                if_req = ($urandom_range(0, 1) == 1); if_addr = $urandom();
            end else if (!if_req && ($urandom_range(0, 2) == 0)) begin
                if_req = 1'b1; if_addr = $urandom();
            end
            flush_if = if_req && ($urandom_range(0, 7) == 0);
            // data requester
            if (mem_req && prev_mem_done) begin
                mem_req = ($urandom_range(0, 1) == 1); mem_we = ($urandom_range(0, 1) == 1);
                mem_addr = $urandom(); mem_wdata = $urandom(); mem_wmask = 4'($urandom_range(0, 15));
            end else if (!mem_req && ($urandom_range(0, 2) == 0)) begin
                mem_req = 1'b1; mem_we = ($urandom_range(0, 1) == 1);
                mem_addr = $urandom(); mem_wdata = $urandom(); mem_wmask = 4'($urandom_range(0, 15));
            end
            // bus slave: random wait states, occasional stray ack when idle
            bus_ack = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            bus_rdata = $urandom();
            smp();
            chk1("r_bus_req", bus_req, m_busy);
            if (m_busy) begin
                chk32("r_bus_addr", bus_addr, m_addr);
                chk1("r_bus_we", bus_we, m_we);
                if (!m_is_fetch) begin
                    chk32("r_bus_wdata", bus_wdata, m_wdata);
                    chk32("r_bus_wmask", 32'(bus_wmask), 32'(m_wmask));
                end
            end
            chk1("r_if_ready", if_ready, e_if_ready);
            chk1("r_mem_ready", mem_ready, e_mem_ready);
            chk32("r_if_rdata", if_rdata, e_if_rdata);
            chk32("r_mem_rdata", mem_rdata, e_mem_rdata);
            s_mem = mem_req & ~e_mem_ready;
            s_if  = (if_req & ~e_if_ready & ~flush_if) | s_mem;
            chk1("r_stall_mem", stall_mem, s_mem);
            chk1("r_stall_if", stall_if, s_if);
`ifdef ARB_PERF_CNT_EN
            chk32("r_perf_if", perf_if, m_perf_if);
            chk32("r_perf_mem", perf_mem, m_perf_mem);
            if (s_if && m_perf_if != 32'hFFFF_FFFF) m_perf_if = m_perf_if + 32'd1;
            if (s_mem && m_perf_mem != 32'hFFFF_FFFF) m_perf_mem = m_perf_mem + 32'd1;
`endif
            prev_if_done = e_if_ready; prev_mem_done = e_mem_ready; prev_flush = flush_if;
            // what the coming edge does, at transaction level
            if_cand = if_req & ~e_if_ready;
            mem_cand = mem_req & ~e_mem_ready;
            e_if_ready = 1'b0; e_mem_ready = 1'b0;
            if (m_busy) begin
                if (bus_ack) begin
                    if (m_is_fetch) begin
                        if (!m_kill && !flush_if) begin e_if_ready = 1'b1; e_if_rdata = bus_rdata; end
                    end else begin
                        e_mem_ready = 1'b1;
                        if (!m_we) e_mem_rdata = bus_rdata;
                    end
                    m_busy = 1'b0;
                end else if (m_is_fetch && flush_if) begin
                    m_kill = 1'b1;
                end
            end else if (mem_cand && (!if_cand || !m_last_data || flush_if)) begin
                m_busy = 1'b1; m_is_fetch = 1'b0; m_kill = 1'b0; m_last_data = 1'b1;
                m_addr = mem_addr; m_we = mem_we; m_wdata = mem_wdata; m_wmask = mem_wmask;
            end else if (if_cand && !flush_if) begin
                m_busy = 1'b1; m_is_fetch = 1'b1; m_kill = 1'b0; m_last_data = 1'b0;
                m_addr = if_addr; m_we = 1'b0;
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
